// File: rtl/bidimen_mux_feeder.sv
// Loads DEPTH words into a flat register bank, then scans a select across
// every entry, holding each code HOLD cycles, to feed a bidimen_mux.
module bidimen_mux_feeder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 19,
    parameter int HOLD  = 4,
    localparam int SEL_WIDTH  = $clog2(DEPTH),
    localparam int TOTAL_BITS = WIDTH * DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  wr_valid_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  start_i,
    output logic                  full_o,
    output logic [SEL_WIDTH:0]    count_o,
    output logic [TOTAL_BITS-1:0] m_in_o,
    output logic [SEL_WIDTH-1:0]  m_ctrl_o,
    output logic                  scan_valid_o,
    output logic                  scan_last_o
);

    localparam int CNT_W  = SEL_WIDTH + 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        READY = 2'd1,
        SCAN  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [TOTAL_BITS-1:0] bank_q, bank_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        bank_d  = bank_q;
        if (clear_i) begin
            state_d = FILL;
            count_d = '0;
            sel_d   = '0;
            hold_d  = '0;
            bank_d  = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (wr_valid_i) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (count_q == CNT_W'(k)) begin
                                bank_d[k*WIDTH +: WIDTH] = wr_data_i;
                            end
                        end
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(DEPTH - 1)) begin
                            state_d = READY;
                        end
                    end
                end
                READY: begin
                    if (start_i) begin
                        state_d = SCAN;
                        sel_d   = '0;
                        hold_d  = '0;
                    end
                end
                SCAN: begin
                    // Select only advances after a full hold period, and the
                    // last code exits straight to FILL instead of wrapping.
                    if (hold_q == HOLD_W'(HOLD - 1)) begin
                        hold_d = '0;
                        if (sel_q == SEL_WIDTH'(DEPTH - 1)) begin
                            state_d = FILL;
                            count_d = '0;
                            sel_d   = '0;
                        end else begin
                            sel_d = sel_q + SEL_WIDTH'(1);
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                    sel_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= FILL;
            count_q <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            bank_q  <= bank_d;
        end
    end

    assign wr_ready_o   = (state_q == FILL);
    assign full_o       = (state_q == READY);
    assign count_o      = count_q;
    assign m_in_o       = bank_q;
    assign m_ctrl_o     = sel_q;
    assign scan_valid_o = (state_q == SCAN);
    assign scan_last_o  = (state_q == SCAN) && (sel_q == SEL_WIDTH'(DEPTH - 1));

endmodule

// File: tb/tb_bidimen_mux_feeder.sv
// Directed scoreboard bench for bidimen_mux_feeder (19x32, HOLD 4)
// plus a small 2x8, HOLD 1 instance for the edge case.
module tb_bidimen_mux_feeder;

    localparam int W = 32;
    localparam int D = 19;
    localparam int H = 4;
    localparam int SW = $clog2(D);

    logic clk = 0;
    logic rstn;
    logic clear, wr_valid, start;
    logic [W-1:0] wr_data;
    logic wr_ready, full, scan_valid, scan_last;
    logic [SW:0] count;
    logic [W*D-1:0] m_in;
    logic [SW-1:0] m_ctrl;

    logic s_clear, s_wr_valid, s_start;
    logic [7:0] s_wr_data;
    logic s_wr_ready, s_full, s_scan_valid, s_scan_last;
    logic [1:0] s_count;
    logic [15:0] s_m_in;
    logic [0:0] s_m_ctrl;

    always #5 clk = ~clk;

    bidimen_mux_feeder #(.WIDTH(W), .DEPTH(D), .HOLD(H)) dut (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clear),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready), .start_i(start), .full_o(full),
        .count_o(count), .m_in_o(m_in), .m_ctrl_o(m_ctrl),
        .scan_valid_o(scan_valid), .scan_last_o(scan_last)
    );

    bidimen_mux_feeder #(.WIDTH(8), .DEPTH(2), .HOLD(1)) dut_s (
        .clk_i(clk), .rstn_i(rstn), .clear_i(s_clear),
        .wr_valid_i(s_wr_valid), .wr_data_i(s_wr_data),
        .wr_ready_o(s_wr_ready), .start_i(s_start), .full_o(s_full),
        .count_o(s_count), .m_in_o(s_m_in), .m_ctrl_o(s_m_ctrl),
        .scan_valid_o(s_scan_valid), .scan_last_o(s_scan_last)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] model [D];
    int exp_sel_q [$];
    logic [W-1:0] exp_dat_q [$];

    // Stand-in for the attached bidimen_mux
    function automatic logic [W-1:0] mux_out();
        return m_in[m_ctrl*W +: W];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input string tag);
        for (int k = 0; k < D; k++) begin
            check(tag, m_in[k*W +: W], model[k]);
        end
    endtask

    task automatic fill(input logic [W-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            wr_valid = 1;
            wr_data = base + W'(k);
            model[int'(count)] = wr_data;
            step();
        end
        wr_valid = 0;
    endtask

    initial begin
        rstn = 0;
        clear = 0; wr_valid = 0; start = 0; wr_data = '0;
        s_clear = 0; s_wr_valid = 0; s_start = 0; s_wr_data = '0;
        for (int k = 0; k < D; k++) model[k] = '0;
        #3;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_scan_valid", scan_valid, 0);
        check("rst_scan_last", scan_last, 0);
        check("rst_m_in", |m_in, 0);
        step();
        rstn = 1;
        step();

        // Fill; start_i on the filling edge must not launch a scan
        fill(32'h1000, D - 1);
        check("fill_count18", count, D - 1);
        check("fill_ready18", wr_ready, 1);
        wr_valid = 1;
        wr_data = 32'h1000 + W'(D - 1);
        model[D-1] = wr_data;
        start = 1;
        step();
        start = 0;
        wr_valid = 0;
        check("full_after_fill", full, 1);
        check("count_after_fill", count, D);
        check("wr_ready_dropped", wr_ready, 0);
        check_bank("fill_bank");
        step();
        check("start_on_entry_ignored", full, 1);
        check("no_scan_yet", scan_valid, 0);

        // Writes offered in READY are ignored
        wr_valid = 1;
        wr_data = 32'hDEADBEEF;
        step();
        step();
        check_bank("ready_ignore_bank");
        check("ready_count", count, D);

        // Scan, writes still offered throughout
        start = 1;
        for (int k = 0; k < D; k++) begin
            for (int h = 0; h < H; h++) begin
                exp_sel_q.push_back(k);
                exp_dat_q.push_back(model[k]);
            end
        end
        step();
        start = 0;
        check("scan_full_low", full, 0);
        begin
            int cyc;
            cyc = 0;
            while (exp_sel_q.size() > 0) begin
                int es;
                logic [W-1:0] ed;
                es = exp_sel_q.pop_front();
                ed = exp_dat_q.pop_front();
                check("scan_valid", scan_valid, 1);
                check("scan_sel", m_ctrl, es);
                check("scan_last", scan_last, es == D - 1);
                check("mux_out", mux_out(), ed);
                cyc++;
                if (exp_sel_q.size() == 0) wr_valid = 0;
                step();
            end
            check("scan_cycles", cyc, D * H);
        end
        check("post_scan_valid", scan_valid, 0);
        check("post_scan_count", count, 0);
        check("post_scan_sel", m_ctrl, 0);
        check("post_scan_wr_ready", wr_ready, 1);
        check_bank("post_scan_bank");

        // start_i in FILL at count 5 is ignored
        fill(32'h2000, 5);
        start = 1;
        step();
        start = 0;
        check("fill_start_ready", wr_ready, 1);
        check("fill_start_count", count, 5);
        check("fill_start_scan", scan_valid, 0);

        // Async reset between edges at count 10
        fill(32'h2005, 5);
        check("pre_rst_count", count, 10);
        #3;
        rstn = 0;
        #1;
        check("async_count", count, 0);
        check("async_m_in", |m_in, 0);
        check("async_wr_ready", wr_ready, 1);
        #2;
        rstn = 1;
        step();
        for (int k = 0; k < D; k++) model[k] = '0;
        fill(32'h3000, D);
        check("refill_full", full, 1);
        check("refill_count", count, D);
        check_bank("refill_bank");

        // Clear mid-scan with a coincident write
        start = 1;
        step();
        start = 0;
        begin
            int budget;
            budget = 0;
            while (m_ctrl != 7 && budget < 100) begin
                step();
                budget++;
            end
            check("reach_sel7", m_ctrl, 7);
        end
        clear = 1;
        wr_valid = 1;
        wr_data = 32'hCAFE0001;
        step();
        clear = 0;
        wr_valid = 0;
        check("clr_wr_ready", wr_ready, 1);
        check("clr_count", count, 0);
        check("clr_m_in", |m_in, 0);
        check("clr_scan_valid", scan_valid, 0);
        check("clr_sel", m_ctrl, 0);
        step();
        check("clr_write_dropped", count, 0);

        // DEPTH=2, HOLD=1 instance
        s_wr_valid = 1;
        s_wr_data = 8'hA1;
        step();
        s_wr_data = 8'hA2;
        step();
        s_wr_valid = 0;
        check("s_full", s_full, 1);
        check("s_bank", s_m_in, 16'hA2A1);
        s_start = 1;
        step();
        s_start = 0;
        check("s_sel0", s_m_ctrl, 0);
        check("s_valid0", s_scan_valid, 1);
        check("s_last0", s_scan_last, 0);
        step();
        check("s_sel1", s_m_ctrl, 1);
        check("s_last1", s_scan_last, 1);
        step();
        check("s_done_valid", s_scan_valid, 0);
        check("s_done_count", s_count, 0);
        check("s_done_ready", s_wr_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bidimen_mux_feeder.md
BIDIMEN_MUX_FEEDER -- requirements
Module: bidimen_mux_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of one entry.
REQ-002 SHALL have parameter DEPTH, default 19, number of entries (DEPTH >= 2).
REQ-003 SHALL have parameter HOLD, default 4, cycles each select value is held during scan (HOLD >= 1).
REQ-004 SHALL derive localparam SEL_WIDTH = $clog2(DEPTH) and TOTAL_BITS = WIDTH*DEPTH.
REQ-005 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rstn_i, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port clear_i, input, 1, synchronous flush request.
REQ-008 SHALL have port wr_valid_i, input, 1, write word offered.
REQ-009 SHALL have port wr_data_i, input, WIDTH, write word.
REQ-010 SHALL have port wr_ready_o, output, 1, block accepts a word this cycle.
REQ-011 SHALL have port start_i, input, 1, begin scan of the loaded bank.
REQ-012 SHALL have port full_o, output, 1, all DEPTH entries loaded and awaiting start.
REQ-013 SHALL have port count_o, output, SEL_WIDTH+1, number of entries written since last fill start.
REQ-014 SHALL have port m_in_o, output, TOTAL_BITS, flat bank; entry k on bits [k*WIDTH +: WIDTH], feeds bidimen_mux m_in.
REQ-015 SHALL have port m_ctrl_o, output, SEL_WIDTH, select, feeds bidimen_mux m_ctrl.
REQ-016 SHALL have port scan_valid_o, output, 1, m_ctrl_o is a live scan select.
REQ-017 SHALL have port scan_last_o, output, 1, m_ctrl_o == DEPTH-1 while scan_valid_o.

Function
REQ-018 SHALL implement three states: FILL, READY, SCAN; all outputs registered or decoded from state registers only.
REQ-019 SHALL assert wr_ready_o only in FILL; a write is accepted when wr_valid_i && wr_ready_o at a rising edge.
REQ-020 SHALL store an accepted word into entry[count_o] and increment count_o by 1 on the same edge.
REQ-021 SHALL move FILL -> READY on the edge accepting the word with count_o == DEPTH-1; count_o then reads DEPTH, full_o = 1.
REQ-022 SHALL ignore start_i in FILL and SCAN, and ignore wr_valid_i in READY and SCAN (no entry change).
REQ-023 SHALL move READY -> SCAN on start_i; next cycle m_ctrl_o = 0, scan_valid_o = 1, full_o = 0.
REQ-024 SHALL hold each m_ctrl_o value exactly HOLD cycles, then increment by 1.
REQ-025 SHALL, after m_ctrl_o == DEPTH-1 has been held HOLD cycles, move SCAN -> FILL with count_o = 0, m_ctrl_o = 0, scan_valid_o = 0; scan occupies exactly DEPTH*HOLD cycles.
REQ-026 SHALL keep m_ctrl_o stable and never exceed DEPTH-1 (no wrap to unused select codes for non-power-of-two DEPTH).
REQ-027 SHALL keep m_in_o constant throughout READY and SCAN; entries retain values until overwritten in a later FILL.
REQ-028 SHALL drive m_ctrl_o = 0, scan_valid_o = 0, scan_last_o = 0 outside SCAN.
REQ-029 SHALL give clear_i highest priority: from any state next cycle is FILL, count_o = 0, all entries 0, m_ctrl_o = 0, hold counter 0; a write coincident with clear_i is discarded.
REQ-030 SHALL give start_i coincident with entering READY no effect (start_i sampled only while already in READY).

Reset
REQ-031 SHALL on rstn_i low, immediately and independent of clk_i, force state FILL, all entries 0, count_o = 0, m_ctrl_o = 0, hold counter 0.
REQ-032 SHALL therefore present during and after reset: wr_ready_o = 1, full_o = 0, scan_valid_o = 0, scan_last_o = 0, m_in_o = 0.
REQ-033 SHALL, on reset asserted mid-fill or mid-scan, discard all progress; first edge after rstn_i rises behaves as fresh FILL.

Verification
REQ-034 Fill: DEPTH=19, write words 0x1000+k for k=0..18 back-to-back -> wr_ready_o drops after 19th accept, full_o=1, count_o=19, m_in_o[k*32+:32]=0x1000+k.
REQ-035 Scan: from READY pulse start_i, HOLD=4 -> m_ctrl_o steps 0..18, each 4 cycles, scan_last_o high last 4 cycles, 76 scan cycles total, then FILL with count_o=0; with bidimen_mux attached m_out=0x1000+m_ctrl_o every scan cycle.
REQ-036 Backpressure/ignore: wr_valid_i held high during READY and SCAN with data 0xDEADBEEF -> no entry changes; start_i pulsed in FILL at count_o=5 -> stays in FILL.
REQ-037 Clear: clear_i at m_ctrl_o=7 during scan, simultaneous wr_valid_i -> next cycle FILL, count_o=0, m_in_o=0, scan_valid_o=0, write dropped.
REQ-038 Async reset: drop rstn_i between clock edges at count_o=10 -> outputs reach reset values before next edge; refill 19 words -> full_o=1 normally.
REQ-039 Edge parameters: DEPTH=2, HOLD=1 -> scan takes 2 cycles, m_ctrl_o 0 then 1; DEPTH=16 -> m_ctrl_o reaches 15 and returns to 0 only via FILL.
